countdown_timer: RTL
====================

# countdown_timer

5-bit countdown timer for the Stop It game. It runs on the same 4 Hz game clock as the up-counting time counter, which is its counterpart. It loads a time budget, counts down one tick per clock while running, and can be paused and resumed. When the budget reaches zero it flags expiry to the game controller: a one-cycle pulse plus a sticky level.

## Interface
- WIDTH, 5, counter width in bits; load value and count output share this width.
- clk_4_i  input  1  4 Hz game clock; all state changes on its rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- load_i  input  1  load load_val_i into the counter this edge.
- load_val_i  input  WIDTH  time budget in ticks, unsigned.
- start_i  input  1  begin or resume counting down.
- pause_i  input  1  freeze counting while running.
- count_o  output  WIDTH  remaining ticks, registered.
- busy_o  output  1  high while in RUN.
- expired_o  output  1  one-cycle pulse on the edge where count reaches 0 through counting or a zero start.
- done_o  output  1  level, high in DONE until the next load.

## Operation
- States:
  - IDLE: loaded, not started.
  - RUN: decrementing.
  - HOLD: paused.
  - DONE: expired.
- Input priority each edge: load_i > pause_i > start_i > decrement.
- IDLE:
  - load_i alone: count <= load_val_i; stay IDLE.
  - start_i with count != 0 (or with load_i and load_val_i != 0): go to RUN, no decrement on this edge.
  - start_i with an effective count of 0: go to DONE, pulse expired_o.
- RUN:
  - Each edge: count <= count - 1.
  - Edge where count goes 1 -> 0: go to DONE, pulse expired_o.
  - pause_i: go to HOLD, no decrement on this edge.
  - load_i: reload; stay in RUN with no decrement on this edge. A load of 0 goes to DONE with an expired_o pulse.
- HOLD:
  - Count frozen.
  - start_i: go to RUN, no decrement on this edge.
  - load_i: reload, stay in HOLD; load with start follows the IDLE rule.
  - pause_i: ignored.
- DONE:
  - count_o = 0.
  - start_i and pause_i ignored.
  - load_i: count <= load_val_i, go to IDLE; load with start follows the IDLE rule.
- pause_i ignored in IDLE and DONE.
- Arithmetic:
  - Unsigned WIDTH-bit arithmetic.
  - Decrement occurs only from count >= 1, so no underflow or wrap is possible.
  - Full-scale load of 31 is legal.

## Timing
- Reset values: state IDLE, count_o = 0, busy_o = 0, expired_o = 0, done_o = 0.
- Reset takes effect immediately on assertion, regardless of the clock.
- Reset mid-RUN discards the count.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Latency for load N, then start sampled at edge E:
  - count_o = N after E, busy_o high.
  - count_o = N - k after E + k.
  - After E + N: count_o = 0, busy_o low, done_o high, expired_o high for exactly one cycle.
- Pause sampled at edge P: count_o holds the value present before P. A start at edge S > P resumes counting, with the first decrement at S + 1.
- expired_o never pulses twice without an intervening load.

## Structure
- Shared package stopit_pkg holds:
  - the timer state enum (IDLE, RUN, HOLD, DONE) as a 2-bit typedef;
  - the TIME_W = 5 constant used for WIDTH defaults across the Stop It blocks.
- Single module with:
  - one always_ff for state, count and the expired pulse;
  - one always_comb for next-state and next-count.
- No sub-module needed.

## Test plan
- Reset mid-count:
  - Stimulus: load 8, start, run 3 ticks, assert rst_ni low between edges.
  - Required: count_o = 0 and state IDLE immediately; no expired_o.
- Basic countdown:
  - Stimulus: load 8, start at E.
  - Required: count_o reads 8, 7, ..., 0 on edges E through E + 8; expired_o high only after E + 8; done_o high from E + 8.
- Pause and resume:
  - Stimulus: load 10, start; pause at count 6; hold 4 cycles; start again.
  - Required: count_o stays 6 throughout HOLD; the next value is 5 one edge after the restart; expiry occurs 6 edges after the restart.
- Zero and full-scale loads:
  - Stimulus: load 0, then start.
  - Required: DONE with an expired_o pulse; count_o stays 0.
  - Stimulus: load 31, then start.
  - Required: expiry after 31 edges, no wrap.
- Simultaneous inputs:
  - Stimulus: load 4 with start in IDLE.
  - Required: RUN with count 4.
  - Stimulus: pause with start in RUN.
  - Required: pause wins, HOLD.
  - Stimulus: load 7 in RUN at count 2.
  - Required: count 7, still RUN.
- Post-expiry:
  - Stimulus: in DONE, pulse start_i and pause_i.
  - Required: no change and no second expired_o.
  - Stimulus: then load 3.
  - Required: IDLE, done_o low, count_o = 3.

Source files
------------

// File: rtl/stopit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopit_pkg
//  Description : Definitions shared by the Stop It game blocks. It holds the
//                game time width and the countdown timer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package stopit_pkg;

    // Width of the game time counters (ticks of the 4 Hz game clock).
    localparam int TIME_W = 5;

    // Countdown timer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // loaded, not started
        ST_RUN  = 2'd1,   // decrementing
        ST_HOLD = 2'd2,   // paused
        ST_DONE = 2'd3    // expired
    } timer_state_t;

endpackage : stopit_pkg
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable, pausable down-counter for the Stop It game. It
//                counts one tick per 4 Hz clock edge while running. On
//                reaching zero it raises a one-cycle expiry pulse and a sticky
//                done level, which holds until the next load.
//  Ports       : clk_4_i     - 4 Hz game clock (rising edge)
//                rst_ni      - asynchronous active-low reset
//                load_i      - load load_val_i this edge
//                load_val_i  - time budget in ticks (unsigned)
//                start_i     - begin / resume counting
//                pause_i     - freeze counting while running
//                count_o     - remaining ticks (registered)
//                busy_o      - high while running
//                expired_o   - one-cycle pulse when the budget runs out
//                done_o      - high while expired, until the next load
//  Revision    : 1.0  initial release
// ============================================================================
module countdown_timer
    import stopit_pkg::*;
#(
    parameter int WIDTH = TIME_W
) (
    input  logic             clk_4_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             pause_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             expired_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_t     r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_expired;

    timer_state_t     w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_expired_nxt;
    logic [WIDTH-1:0] w_eff_count;

    // A start sees the freshly loaded value when load and start coincide.
    assign w_eff_count = load_i ? load_val_i : r_count;

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_expired_nxt = 1'b0;

        case (r_state)
            ST_IDLE, ST_HOLD: begin
                // Pause has no effect here; start (possibly with load) wins.
                if (start_i) begin
                    if (w_eff_count != C_ZERO) begin
                        w_state_nxt = ST_RUN;
                        w_count_nxt = w_eff_count;
                    end else begin
                        w_state_nxt   = ST_DONE;
                        w_count_nxt   = C_ZERO;
                        w_expired_nxt = 1'b1;
                    end
                end else if (load_i) begin
                    w_count_nxt = load_val_i;
                end
            end

            ST_RUN: begin
                if (load_i) begin
                    // A reload while running does not decrement on this edge.
                    w_count_nxt = load_val_i;
                    if (load_val_i == C_ZERO) begin
                        w_state_nxt   = ST_DONE;
                        w_expired_nxt = 1'b1;
                    end
                end else if (pause_i) begin
                    w_state_nxt = ST_HOLD;
                end else if (r_count == C_ONE) begin
                    w_state_nxt   = ST_DONE;
                    w_count_nxt   = C_ZERO;
                    w_expired_nxt = 1'b1;
                end else if (r_count == C_ZERO) begin
                    // RUN is never entered with a zero count. Recover quietly
                    // without a pulse rather than wrapping.
                    w_state_nxt = ST_DONE;
                end else begin
                    w_count_nxt = r_count - C_ONE;
                end
            end

            ST_DONE: begin
                w_count_nxt = C_ZERO;
                if (load_i) begin
                    if (start_i) begin
                        if (load_val_i != C_ZERO) begin
                            w_state_nxt = ST_RUN;
                            w_count_nxt = load_val_i;
                        end else begin
                            // Reload of zero with start: expire again. This
                            // is a new load, so a second pulse is allowed.
                            w_expired_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = load_val_i;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = C_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_count   <= C_ZERO;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    // Outputs come straight from registers or are decoded from the state
    // register only, so inputs have no combinational path to them.
    assign count_o   = r_count;
    assign expired_o = r_expired;
    assign busy_o    = (r_state == ST_RUN);
    assign done_o    = (r_state == ST_DONE);

endmodule : countdown_timer
`default_nettype wire
